// File: rtl/btn_led_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_led_arbiter_pkg
// Description : Shared types and constants for the pushbutton LED arbiter.
//               Holds the arbiter state encoding, the requester count and the
//               round-robin winner search used by the arbiter FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_led_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int REQ_W   = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // First set request found when scanning upward from last+1, wrapping.
    // The last granted requester therefore has the lowest priority.
    // Returns 'last' when nothing is requested; callers gate on |req.
    function automatic logic [REQ_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [REQ_W-1:0]   last
    );
        logic [REQ_W-1:0] pick;
        logic [REQ_W-1:0] idx;
        logic             found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = REQ_W'((int'(last) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage : btn_led_arbiter_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : One active-low pushbutton: 2-flop synchronizer, debounce
//               counter and a one-cycle press pulse on a debounced 1->0 edge.
// Ports       : clk      - system clock
//               rst_n    - asynchronous active-low reset
//               btn_i    - raw asynchronous button (0 = pressed)
//               press_o  - registered one-cycle pulse per accepted press
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int               CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    // Everything resets to "released" so reset release never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                // DB_CYCLES disagreeing samples in a row: accept the new level.
                // Only the released->pressed direction produces an event.
                stable_q <= sync2_q;
                cnt_q    <= '0;
                press_q  <= stable_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/btn_led_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : btn_led_arbiter
// Description : Four debounced pushbuttons share one LED display. Presses
//               latch into pending flags; a round-robin FSM grants one
//               requester at a time for a fixed hold period, followed by a
//               dark gap before the next grant.
// Ports       : clk        - system clock (rising edge)
//               rst_n      - asynchronous active-low reset
//               btn_i      - raw active-low buttons, one per requester
//               led_o      - one-hot display, lit for the owner during HOLD
//               owner_o    - current or last granted requester
//               busy_o     - high in HOLD or GAP
//               pending_o  - latched requests awaiting service
// Revision    : 1.0 - initial release
// ============================================================================
module btn_led_arbiter
    import btn_led_arbiter_pkg::*;
#(
    parameter int DB_CYCLES   = 500000,
    parameter int HOLD_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 5000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] btn_i,
    output logic [NUM_REQ-1:0] led_o,
    output logic [REQ_W-1:0]   owner_o,
    output logic               busy_o,
    output logic [NUM_REQ-1:0] pending_o
);

    localparam int                 TMAX      = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int                 CNT_W     = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

    logic [NUM_REQ-1:0] press;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
            btn_debounce #(
                .DB_CYCLES (DB_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .rst_n   (rst_n),
                .btn_i   (btn_i[i]),
                .press_o (press[i])
            );
        end
    endgenerate

    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [REQ_W-1:0]   owner_q,   owner_d;
    logic [NUM_REQ-1:0] pend_q,    pend_d;
    logic [NUM_REQ-1:0] led_q;
    logic               busy_q;
    logic [REQ_W-1:0]   winner;

    // The timer counts down from (length-1) and is reloaded on each state
    // entry, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        pend_d  = pend_q | press;
        winner  = rr_pick(pend_q, owner_q);
        unique case (state_q)
            ST_IDLE: begin
                if (|pend_q) begin
                    state_d        = ST_HOLD;
                    cnt_d          = HOLD_LOAD;
                    owner_d        = winner;
                    // A coincident press of the winner is absorbed by the grant.
                    pend_d[winner] = 1'b0;
                end
            end
            ST_HOLD: begin
                if (press[owner_q] || (cnt_q == '0)) begin
                    // A repeat press by the owner cuts the hold short and is
                    // not re-queued; the owner's flag is already clear otherwise.
                    state_d         = ST_GAP;
                    cnt_d           = GAP_LOAD;
                    pend_d[owner_q] = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            owner_q <= REQ_W'(NUM_REQ - 1);   // requester 0 searched first
            pend_q  <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            pend_q  <= pend_d;
            led_q   <= (state_d == ST_HOLD) ? (ONE_HOT0 << owner_d) : '0;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign led_o     = led_q;
    assign owner_o   = owner_q;
    assign busy_o    = busy_q;
    assign pending_o = pend_q;

endmodule : btn_led_arbiter
`default_nettype wire

// File: tb/tb_btn_led_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_led_arbiter
// Description : Self-checking bench for btn_led_arbiter. A reference model
//               derives press events from the raw button history and tracks
//               grants on an absolute timeline; it queues the expected status
//               each cycle and each completed grant. A monitor on the falling
//               edge pops and compares against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_btn_led_arbiter;

    localparam int DB = 4;
    localparam int H  = 8;
    localparam int G  = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn   = 4'hF;
    logic [3:0] led;
    logic [3:0] pending;
    logic [1:0] owner;
    logic       busy;

    int checks = 0;
    int errors = 0;

    btn_led_arbiter #(
        .DB_CYCLES   (DB),
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_i     (btn),
        .led_o     (led),
        .owner_o   (owner),
        .busy_o    (busy),
        .pending_o (pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] led;
        logic [3:0] pend;
        logic       busy;
        logic [1:0] owner;
    } status_t;

    typedef struct {
        int owner;
        int len;
    } grant_t;

    status_t exp_q[$];
    grant_t  grant_q[$];

    // ---------------- reference model ----------------
    logic [3:0] hist [0:DB+1];   // hist[0] = raw sample at this edge
    logic [3:0] lvl;
    logic [3:0] fall_prev;
    logic [3:0] m_pend;
    int         k, hold_until, gap_until, grant_k, m_owner;
    int         model_grants = 0;

    always @(posedge clk) begin : p_model
        logic [3:0] ev;
        logic [3:0] fall_now;
        logic [3:0] pend_b;
        bit         all_diff;
        int         st_b;
        int         w;
        status_t    s;
        grant_t     g;
        if (!rst_n) begin
            for (int j = 0; j <= DB + 1; j++) hist[j] = 4'hF;
            lvl        = 4'hF;
            fall_prev  = 4'h0;
            m_pend     = 4'h0;
            m_owner    = 3;
            k          = 0;
            hold_until = 0;
            gap_until  = 0;
            grant_k    = 0;
        end else begin
            k++;
            for (int j = DB + 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = btn;
            // Synchronizer delays by two samples; the level flips once the
            // last DB delayed samples all disagree with it.
            fall_now = 4'h0;
            for (int i = 0; i < 4; i++) begin
                all_diff = 1'b1;
                for (int j = 2; j <= DB + 1; j++)
                    if (hist[j][i] == lvl[i]) all_diff = 1'b0;
                if (all_diff) begin
                    fall_now[i] = lvl[i];
                    lvl[i]      = ~lvl[i];
                end
            end
            ev        = fall_prev;     // pending reacts one edge after the flip
            fall_prev = fall_now;

            // State in force before this edge: 1 = HOLD, 2 = GAP, 0 = IDLE
            st_b   = (k - 1 < hold_until) ? 1 : ((k - 1 < gap_until) ? 2 : 0);
            pend_b = m_pend;
            m_pend = m_pend | ev;
            if (st_b == 0 && pend_b != 4'h0) begin
                w = m_owner;
                for (int d = 4; d >= 1; d--)
                    if (pend_b[(m_owner + d) % 4]) w = (m_owner + d) % 4;
                m_owner    = w;
                m_pend[w]  = 1'b0;
                grant_k    = k;
                hold_until = k + H;
                gap_until  = k + H + G;
                model_grants++;
            end else if (st_b == 1 && ev[m_owner]) begin
                m_pend[m_owner] = 1'b0;
                hold_until      = k;
                gap_until       = k + G;
            end
            if (st_b == 1 && k >= hold_until) begin
                g.owner = m_owner;
                g.len   = k - grant_k;
                grant_q.push_back(g);
            end
            s.led   = (k < hold_until) ? 4'(1 << m_owner) : 4'h0;
            s.pend  = m_pend;
            s.busy  = (k < gap_until);
            s.owner = 2'(m_owner);
            exp_q.push_back(s);
        end
    end

    // ---------------- monitor ----------------
    int         lit_len      = 0;
    int         seen_grants  = 0;
    logic [3:0] prev_led     = 4'h0;

    always @(negedge clk) begin : p_monitor
        status_t s;
        status_t a;
        grant_t  g;
        int      idx;
        if (!rst_n) begin
            exp_q.delete();
            grant_q.delete();
            lit_len  = 0;
            prev_led = 4'h0;
        end else begin
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                a = {led, pending, busy, owner};
                checks++;
                if (a !== s) begin
                    errors++;
                    $display("FAIL status t=%0t got led=%b pend=%b busy=%b owner=%0d, expected led=%b pend=%b busy=%b owner=%0d",
                             $time, led, pending, busy, owner, s.led, s.pend, s.busy, s.owner);
                end
            end
            if (led != 4'h0) begin
                if (prev_led == 4'h0) seen_grants++;
                lit_len++;
            end else if (prev_led != 4'h0) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (prev_led[i]) idx = i;
                checks++;
                if (grant_q.size() == 0) begin
                    errors++;
                    $display("FAIL grant_end t=%0t got owner=%0d len=%0d, expected no grant", $time, idx, lit_len);
                end else begin
                    g = grant_q.pop_front();
                    if (g.owner != idx || g.len != lit_len) begin
                        errors++;
                        $display("FAIL grant_end t=%0t got owner=%0d len=%0d, expected owner=%0d len=%0d",
                                 $time, idx, lit_len, g.owner, g.len);
                    end
                end
                lit_len = 0;
            end
            prev_led = led;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if (led !== 4'h0 || pending !== 4'h0 || busy !== 1'b0 || owner !== 2'd3) begin
            errors++;
            $display("FAIL %s got led=%b pend=%b busy=%b owner=%0d, expected led=0000 pend=0000 busy=0 owner=3",
                     tag, led, pending, busy, owner);
        end
    endtask

    // Assert reset between edges and look at the outputs before any clock.
    task automatic async_reset_check(input string tag);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_state(tag);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog t=%0t simulation did not complete", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : p_stim
        btn   = 4'hF;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_state("reset_state");
        rst_n = 1'b1;
        step(5);

        // single press of requester 2, held 10 cycles
        btn = 4'b1011; step(10);
        btn = 4'hF;    step(25);

        // all four pressed together: grants 0,1,2,3
        btn = 4'b0000; step(10);
        btn = 4'hF;    step(55);

        // 3-cycle glitch on requester 1: no request
        btn = 4'b1101; step(3);
        btn = 4'hF;    step(20);

        // owner 1 releases and presses again mid-hold: early end
        btn = 4'b1101; step(4);
        btn = 4'hF;    step(4);
        btn = 4'b1101; step(6);
        btn = 4'hF;    step(25);

        // requester 0 presses during owner 3's hold
        btn = 4'b0111; step(3);
        btn = 4'b0110; step(8);
        btn = 4'hF;    step(40);

        // reset mid-hold, then 1 and 2 together
        btn = 4'b1110; step(5);
        btn = 4'hF;    step(8);
        async_reset_check("reset_mid_hold");
        btn = 4'b1001; step(6);
        btn = 4'hF;    step(40);

        // random phase, buttons biased toward released
        for (int r = 0; r < 80; r++) begin
            btn = 4'($urandom) | 4'($urandom);
            step(int'($urandom_range(1, 12)));
            if (r == 40) async_reset_check("reset_random");
        end
        btn = 4'hF;
        step(60);

        checks++;
        if (grant_q.size() != 0 || seen_grants != model_grants) begin
            errors++;
            $display("FAIL grant_count got seen=%0d leftover=%0d, expected seen=%0d leftover=0",
                     seen_grants, grant_q.size(), model_grants);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_btn_led_arbiter
`default_nettype wire

// File: doc/btn_led_arbiter.md
BTN_LED_ARBITER -- requirements
Module: btn_led_arbiter

Interface
REQ-001 Parameter DB_CYCLES, default 500000, consecutive stable synchronized samples needed to accept a button level change (min 2).
REQ-002 Parameter HOLD_CYCLES, default 25000000, cycles the granted LED stays lit (min 1).
REQ-003 Parameter GAP_CYCLES, default 5000000, cycles all LEDs stay dark between grants (min 1).
REQ-004 clk  input  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 btn  input  4  raw asynchronous pushbuttons, active-low (0 = pressed); each bit is one requester.
REQ-007 led  output  4  one-hot display; bit i lit while requester i owns the display.
REQ-008 owner  output  2  index of current or last granted requester.
REQ-009 busy  output  1  high in HOLD or GAP.
REQ-010 pending  output  4  registered request flags awaiting service.

Function
REQ-011 Each btn bit SHALL pass a 2-flop synchronizer, then a debouncer that updates its stable level only after DB_CYCLES consecutive synchronized samples differing from the current stable level; any agreeing sample clears the count.
REQ-012 A press event SHALL be a debounced 1->0 transition; it sets pending[i] on the next edge, i.e. exactly DB_CYCLES+3 cycles after btn[i] goes low and stays low.
REQ-013 Release (0->1) SHALL produce no event; holding a button SHALL raise only one request.
REQ-014 FSM states: IDLE, HOLD, GAP, defined in the shared package.
REQ-015 IDLE: if pending != 0, the next state is HOLD; owner SHALL load the winner and the winner's pending bit SHALL clear on the same edge. Otherwise the FSM remains in IDLE.
REQ-016 Winner SHALL be the first set pending bit searched round-robin from owner+1 (mod 4) upward.
REQ-017 HOLD SHALL last exactly HOLD_CYCLES cycles, with led = one-hot(owner); the transition is to GAP.
REQ-018 A press event from the current owner during HOLD SHALL end HOLD early: the next state is GAP and pending[owner] SHALL stay clear.
REQ-019 A press event from a non-owner during HOLD or GAP SHALL only set that pending bit; an already-set pending bit stays set (no counting).
REQ-020 GAP SHALL last exactly GAP_CYCLES cycles with led = 0, then the FSM SHALL enter IDLE.
REQ-021 led SHALL be 0 in IDLE and GAP; at most one led bit SHALL be high in any cycle.
REQ-022 If a press event on bit i coincides with the grant of bit i, pending[i] SHALL end clear; the grant wins.
REQ-023 Cycle counters SHALL be sized as $clog2 of the largest parameter and SHALL never wrap; they reload on every state entry.
REQ-024 busy SHALL be a registered function of state only.

Reset
REQ-025 While rst_n=0: state=IDLE, owner=3 (so btn[0] has first priority), pending=0, led=0, busy=0, counters=0.
REQ-026 Synchronizer and debounced levels SHALL reset to 1 (released); no press event SHALL result from reset release while buttons are up.
REQ-027 Reset asserted mid-HOLD or mid-GAP SHALL abort immediately; the FSM SHALL resume in IDLE with no stale grants.

Structure
REQ-028 Package btn_led_arbiter_pkg SHALL hold the state_t enum and the NUM_REQ=4 constant.
REQ-029 Sub-module btn_debounce (one bit: synchronizer + debounce counter + press-event pulse) SHALL be instantiated NUM_REQ times.
REQ-030 Arbiter FSM, round-robin selection and timers SHALL reside in btn_led_arbiter.

Verification (DB_CYCLES=4, HOLD_CYCLES=8, GAP_CYCLES=2)
REQ-031 Reset, then btn[2] low for 10 cycles -> pending[2] high at cycle 7; led=0100 for exactly 8 cycles; then led=0000 for 2 cycles; then IDLE.
REQ-032 btn[0..3] pressed in the same cycle after reset -> grants in the order 0,1,2,3, each an 8-cycle HOLD separated by a 2-cycle GAP; pending drains 1111->1110->1100->1000->0000.
REQ-033 btn[1] glitches low for 3 cycles only -> no pending, led stays 0000.
REQ-034 During owner 1's HOLD, btn[1] is released and pressed again -> HOLD ends at that event; GAP follows; pending[1]=0.
REQ-035 During owner 3's HOLD, btn[0] is pressed -> pending[0]=1 and led stays 1000 through the full HOLD; owner 0 is granted after the GAP.
REQ-036 rst_n pulsed low mid-HOLD -> led=0000 and pending=0000 asynchronously; the next grant begins at btn[0] priority.
